// File: rtl/ex_div_pkg.sv
// Shared constants and types for the RV32M execute-stage divider.
package ex_div_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CNT_W_DEF = 5;

  // funct3 encodings of the M-extension divide group
  localparam logic [2:0] OP_DIV  = 3'b100;
  localparam logic [2:0] OP_DIVU = 3'b101;
  localparam logic [2:0] OP_REM  = 3'b110;
  localparam logic [2:0] OP_REMU = 3'b111;

  // Reset / idle values and output levels
  localparam logic [XLEN_DEF-1:0] ZeroWord = '0;
  localparam logic [4:0]          ZeroReg  = '0;
  localparam logic                Enable   = 1'b1;
  localparam logic                Disable  = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_CALC  = 2'd2,
    S_END   = 2'd3
  } div_state_e;

  // Operation captured at acceptance; nothing downstream looks at the live inputs
  typedef struct packed {
    logic [2:0]          op;
    logic [XLEN_DEF-1:0] dividend;
    logic [XLEN_DEF-1:0] divisor;
    logic [4:0]          waddr;
  } div_req_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [2:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/ex_div.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in the execute stage.
// Holds the pipeline while working and pulses ready_o with the result.
module ex_div
  import ex_div_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  input  logic [4:0]      reg_waddr_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            busy_o,
  output logic            hold_req_o,
  output logic [4:0]      reg_waddr_o
);

  localparam logic [XLEN-1:0]  MinNeg  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]  AllOnes = '1;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] neg(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  div_state_e       state_q, state_d;
  div_req_t         req_q;
  logic [XLEN-1:0]  rem_q;
  logic [XLEN-1:0]  quo_q;
  logic [XLEN-1:0]  dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             q_neg_q, r_neg_q;

  logic             accept;
  logic             req_signed, req_rem;
  logic             div_zero, overflow, special;
  logic [XLEN-1:0]  special_res;
  logic [XLEN:0]    rem_sh, diff;
  logic             ge;
  logic [XLEN-1:0]  rem_n, quo_n;
  logic [XLEN-1:0]  q_final, r_final;
  logic             last_step, load_result;

  // Issue decode and special-case detection on the latched request
  always_comb begin
    accept      = (state_q == S_IDLE) && start_i && !flush_i;
    req_signed  = op_is_signed(req_q.op);
    req_rem     = op_is_rem(req_q.op);
    div_zero    = (req_q.divisor == ZeroWord);
    overflow    = req_signed && (req_q.dividend == MinNeg) && (req_q.divisor == AllOnes);
    special     = div_zero || overflow;
    special_res = ZeroWord;
    if (div_zero)
      special_res = req_rem ? req_q.dividend : AllOnes;
    else if (overflow)
      special_res = req_rem ? ZeroWord : MinNeg;
  end

  // One restoring step. The shifted partial remainder is XLEN+1 bits; since
  // it never exceeds 2*divisor-1 the MSB of the difference is a clean borrow.
  always_comb begin
    rem_sh = {rem_q, quo_q[XLEN-1]};
    diff   = rem_sh - {1'b0, dvs_q};
    ge     = ~diff[XLEN];
    rem_n  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_n  = {quo_q[XLEN-2:0], ge};
  end

  // Sign fix-up of the final step, registered into result_o on entry to END
  // so the value is valid during the ready_o cycle.
  always_comb begin
    q_final     = q_neg_q ? neg(quo_n) : quo_n;
    r_final     = r_neg_q ? neg(rem_n) : rem_n;
    last_step   = (state_q == S_CALC) && (cnt_q == LastCnt);
    load_result = !flush_i && (((state_q == S_START) && special) || last_step);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a flush overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_START;
      S_START: state_d = special ? S_END : S_CALC;
      S_CALC:  if (cnt_q == LastCnt) state_d = S_END;
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Operand capture, setup and iteration registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q   <= '0;
      rem_q   <= ZeroWord;
      quo_q   <= ZeroWord;
      dvs_q   <= ZeroWord;
      cnt_q   <= '0;
      q_neg_q <= Disable;
      r_neg_q <= Disable;
    end else begin
      if (accept)
        req_q <= '{op: op_i, dividend: dividend_i, divisor: divisor_i, waddr: reg_waddr_i};
      if ((state_q == S_START) && !flush_i && !special) begin
        quo_q   <= (req_signed && req_q.dividend[XLEN-1]) ? neg(req_q.dividend) : req_q.dividend;
        dvs_q   <= (req_signed && req_q.divisor[XLEN-1])  ? neg(req_q.divisor)  : req_q.divisor;
        rem_q   <= ZeroWord;
        cnt_q   <= '0;
        q_neg_q <= req_signed && !div_zero && (req_q.dividend[XLEN-1] ^ req_q.divisor[XLEN-1]);
        r_neg_q <= req_signed && req_q.dividend[XLEN-1];
      end
      if ((state_q == S_CALC) && !flush_i) begin
        rem_q <= rem_n;
        quo_q <= quo_n;
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Result, destination and one-cycle ready pulse (high exactly in END)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_o    <= ZeroWord;
      reg_waddr_o <= ZeroReg;
      ready_o     <= Disable;
    end else begin
      ready_o <= load_result ? Enable : Disable;
      if (load_result) begin
        reg_waddr_o <= req_q.waddr;
        if (state_q == S_START) result_o <= special_res;
        else                    result_o <= req_rem ? r_final : q_final;
      end
    end
  end

  assign busy_o     = (state_q == S_START) || (state_q == S_CALC);
  assign hold_req_o = busy_o || accept;

endmodule

// File: tb/tb_ex_div.sv
// Self-checking bench for ex_div: directed cases, flush/reset corners and
// random operations against a plain-arithmetic RV32M reference.
module tb_ex_div;

  localparam logic [2:0] F_DIV  = 3'b100;
  localparam logic [2:0] F_DIVU = 3'b101;
  localparam logic [2:0] F_REM  = 3'b110;
  localparam logic [2:0] F_REMU = 3'b111;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  reg_waddr_i;
  logic        flush_i;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;
  logic        hold_req_o;
  logic [4:0]  reg_waddr_o;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_wa  = '0;

  ex_div dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .op_i        (op_i),
    .dividend_i  (dividend_i),
    .divisor_i   (divisor_i),
    .reg_waddr_i (reg_waddr_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .ready_o     (ready_o),
    .busy_o      (busy_o),
    .hold_req_o  (hold_req_o),
    .reg_waddr_o (reg_waddr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RV32M semantics straight from the ISA rules
  function automatic logic [31:0] ref_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic is_rem, sgn;
    int sa, sb;
    is_rem = (op == F_REM) || (op == F_REMU);
    sgn    = (op == F_DIV) || (op == F_REM);
    if (b == 0) return is_rem ? a : 32'hFFFF_FFFF;
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return is_rem ? 32'h0 : 32'h8000_0000;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic sgn;
    sgn = (op == F_DIV) || (op == F_REM);
    if (b == 0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
    return 34;
  endfunction

  // Issue one op in cycle C and watch C+1..C+38 for the single ready pulse
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic [31:0] exp_res, input int exp_lat,
                        input string tag);
    int first_rdy, n_rdy;
    logic [31:0] got_res;
    logic [4:0]  got_wa;
    first_rdy = -1;
    n_rdy     = 0;
    got_res   = 'x;
    got_wa    = 'x;
    @(negedge clk);
    start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = wa;
    #1 chk({tag, "_hold"}, 32'(hold_req_o), 32'd1);
    for (int k = 1; k <= 38; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start_i = 1'b0;
        dividend_i = $urandom; divisor_i = $urandom; reg_waddr_i = 5'($urandom);
      end
      #1;
      if (k == 1) chk({tag, "_busy"}, 32'(busy_o), 32'd1);
      if (ready_o) begin
        if (first_rdy < 0) begin
          first_rdy = k; got_res = result_o; got_wa = reg_waddr_o;
        end
        n_rdy++;
      end
    end
    chk({tag, "_lat"},  32'(first_rdy), 32'(exp_lat));
    chk({tag, "_npls"}, 32'(n_rdy), 32'd1);
    chk({tag, "_res"},  got_res, exp_res);
    chk({tag, "_wa"},   32'(got_wa), 32'(wa));
    last_res = exp_res;
    last_wa  = wa;
  endtask

  initial begin
    int n;
    int rk[2];
    logic [31:0] rr[2];
    logic [4:0]  rw[2];

    rst = 1'b0; start_i = 1'b0; op_i = '0; dividend_i = '0; divisor_i = '0;
    reg_waddr_i = '0; flush_i = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_res",   result_o, 32'd0);
    chk("rst_rdy",   32'(ready_o), 32'd0);
    chk("rst_busy",  32'(busy_o), 32'd0);
    chk("rst_hold",  32'(hold_req_o), 32'd0);
    chk("rst_wa",    32'(reg_waddr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed arithmetic
    run_op(F_DIVU, 32'd100, 32'd7, 5'd3, 32'd14, 34, "divu_100_7");
    run_op(F_REMU, 32'd100, 32'd7, 5'd4, 32'd2, 34, "remu_100_7");
    run_op(F_DIV,  32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 34, "div_m7_2");
    run_op(F_REM,  32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 34, "rem_m7_2");
    run_op(F_DIV,  32'd7, 32'hFFFF_FFFE, 5'd7, 32'hFFFF_FFFD, 34, "div_7_m2");
    run_op(F_REM,  32'd7, 32'hFFFF_FFFE, 5'd8, 32'd1, 34, "rem_7_m2");
    run_op(F_DIVU, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 2, "divu_5_0");
    run_op(F_REMU, 32'd5, 32'd0, 5'd10, 32'd5, 2, "remu_5_0");
    run_op(F_DIV,  32'hFFFF_FFFB, 32'd0, 5'd11, 32'hFFFF_FFFF, 2, "div_m5_0");
    run_op(F_REM,  32'hFFFF_FFFB, 32'd0, 5'd12, 32'hFFFF_FFFB, 2, "rem_m5_0");
    run_op(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 2, "div_ovf");
    run_op(F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 2, "rem_ovf");
    run_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'd0, 34, "divu_ovf");

    // Flush in the 10th CALC cycle
    @(negedge clk);
    start_i = 1'b1; op_i = F_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd20;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    #1 chk("fl_busy_before", 32'(busy_o), 32'd1);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    chk("fl_busy_after", 32'(busy_o), 32'd0);
    chk("fl_hold_after", 32'(hold_req_o), 32'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o) n++;
      @(negedge clk);
      #1;
    end
    chk("fl_no_rdy", 32'(n), 32'd0);
    chk("fl_res_kept", result_o, last_res);
    chk("fl_wa_kept", 32'(reg_waddr_o), 32'(last_wa));
    run_op(F_DIVU, 32'd9, 32'd3, 5'd21, 32'd3, 34, "divu_9_3");

    // Flush and start together in IDLE: nothing accepted
    @(negedge clk);
    start_i = 1'b1; flush_i = 1'b1; op_i = F_DIVU; dividend_i = 32'd50; divisor_i = 32'd5; reg_waddr_i = 5'd22;
    #1 chk("fs_hold", 32'(hold_req_o), 32'd0);
    @(negedge clk);
    start_i = 1'b0; flush_i = 1'b0;
    #1 chk("fs_busy", 32'(busy_o), 32'd0);
    n = 0;
    for (int k = 0; k < 40; k++) begin
      if (ready_o) n++;
      @(negedge clk);
      #1;
    end
    chk("fs_no_rdy", 32'(n), 32'd0);
    chk("fs_res_kept", result_o, last_res);

    // start_i held high: second op accepted only in the IDLE cycle after END
    @(negedge clk);
    start_i = 1'b1; op_i = F_DIVU; dividend_i = 32'd1000; divisor_i = 32'd10; reg_waddr_i = 5'd7;
    n = 0;
    rk[0] = -1; rk[1] = -1; rr[0] = 'x; rr[1] = 'x; rw[0] = 'x; rw[1] = 'x;
    for (int k = 1; k <= 72; k++) begin
      @(negedge clk);
      if (k == 1) begin
        op_i = F_REMU; dividend_i = 32'd80; divisor_i = 32'd7; reg_waddr_i = 5'd9;
      end
      if (k == 36) start_i = 1'b0;
      #1;
      if (k == 34) chk("held_end_hold", 32'(hold_req_o), 32'd0);
      if (k == 35) chk("held_idle_hold", 32'(hold_req_o), 32'd1);
      if (ready_o) begin
        if (n < 2) begin rk[n] = k; rr[n] = result_o; rw[n] = reg_waddr_o; end
        n++;
      end
    end
    chk("held_npls", 32'(n), 32'd2);
    chk("held_lat0", 32'(rk[0]), 32'd34);
    chk("held_res0", rr[0], 32'd100);
    chk("held_wa0",  32'(rw[0]), 32'd7);
    chk("held_lat1", 32'(rk[1]), 32'd69);
    chk("held_res1", rr[1], 32'd3);
    chk("held_wa1",  32'(rw[1]), 32'd9);

    // Asynchronous reset in the middle of CALC
    @(negedge clk);
    start_i = 1'b1; op_i = F_DIVU; dividend_i = 32'd12345; divisor_i = 32'd11; reg_waddr_i = 5'd17;
    @(negedge clk);
    start_i = 1'b0;
    repeat (5) @(negedge clk);
    #1 chk("ar_busy_before", 32'(busy_o), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("ar_res",  result_o, 32'd0);
    chk("ar_rdy",  32'(ready_o), 32'd0);
    chk("ar_busy", 32'(busy_o), 32'd0);
    chk("ar_hold", 32'(hold_req_o), 32'd0);
    chk("ar_wa",   32'(reg_waddr_o), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    last_res = '0;
    last_wa  = '0;

    // Random operations against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int sel;
      op  = {1'b1, 2'($urandom_range(0, 3))};
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0)      b = 32'd0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel < 5)  b = 32'($urandom_range(1, 255));
      else if (sel == 5) b = -32'($urandom_range(1, 255));
      else if (sel == 6) a = 32'($urandom_range(0, 15));
      run_op(op, a, b, 5'($urandom), ref_div(op, a, b), ref_lat(op, a, b), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
